// File: rtl/ariane_pkg.sv
// Shared frontend types for the BHT checkpoint controller: update record,
// controller FSM states and default sizing.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
    } bht_update_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWITCH,
        DONE
    } bht_ckpt_state_e;

    localparam int unsigned BHT_CKPT_DEPTH     = 4;
    localparam int unsigned BHT_CKPT_MAX_DRAIN = 64;

endpackage

// File: rtl/bht_ckpt_ctrl_if.sv
// Mode-switch handshake between the checkpoint requester and the BHT
// checkpoint controller, plus the resulting mode seen by the selector.
interface bht_ckpt_ctrl_if;

    logic ckpt_req;
    logic ckpt_target;
    logic ckpt_ack;
    logic checkpoint_mode;

    modport master (
        output ckpt_req,
        output ckpt_target,
        input  ckpt_ack,
        input  checkpoint_mode
    );

    modport slave (
        input  ckpt_req,
        input  ckpt_target,
        output ckpt_ack,
        output checkpoint_mode
    );

endinterface

// File: rtl/fifo_v3.sv
// Non-fall-through FIFO: data_o shows the head entry, push and pop may
// coincide even when full, flush_i empties it and overrides push/pop.
module fifo_v3 #(
    parameter int unsigned DEPTH      = 4,
    parameter type         dtype      = logic,
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [ADDR_DEPTH:0] usage_o,
    input  dtype                data_i,
    input  logic                push_i,
    output dtype                data_o,
    input  logic                pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;
    dtype                  mem_q [DEPTH];

    assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // When full, a pop frees the head slot in the same cycle, so the push
    // may land in it (the write pointer equals the read pointer then).
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bht_ckpt_ctrl.sv
// Buffers resolved BHT updates for the checkpointed selector and switches the
// checkpoint mode only once every old-mode update has been issued or dropped.
module bht_ckpt_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH     = BHT_CKPT_DEPTH,
    parameter int unsigned MAX_DRAIN = BHT_CKPT_MAX_DRAIN,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             debug_mode_i,
    input  bht_update_t      bht_update_i,
    bht_ckpt_ctrl_if.slave   ckpt_if,
    output bht_update_t      bht_update_o,
    output logic             fifo_full_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DRAIN_W = (MAX_DRAIN > 1) ? $clog2(MAX_DRAIN) : 1;

    bht_ckpt_state_e    state_q, state_d;
    logic               mode_q, mode_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    bht_update_t        upd_q, upd_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_flush;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ADDR_W:0]    fifo_usage;
    bht_update_t        fifo_data;

    logic               push_req;
    logic               quiet;
    logic               force_drain;
    logic [CNT_W:0]     drop_inc;
    logic [CNT_W:0]     drop_sum;

    assign push_req    = bht_update_i.valid & ~debug_mode_i & ~flush_i;
    assign quiet       = fifo_empty & ~upd_q.valid & ~push_req;
    assign force_drain = (state_q == DRAIN) & ~quiet
                       & (drain_cnt_q == DRAIN_W'(MAX_DRAIN - 1));

    // A push arriving with a forced discard or in SWITCH would be issued
    // under the new mode, so it is refused and counted as a drop.
    assign fifo_flush = flush_i | force_drain;
    assign fifo_pop   = ~fifo_empty & ~fifo_flush;
    assign fifo_push  = push_req & ~force_drain & (state_q != SWITCH)
                      & (~fifo_full | fifo_pop);

    fifo_v3 #(
        .DEPTH (DEPTH),
        .dtype (bht_update_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (fifo_flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (bht_update_i),
        .push_i  (fifo_push),
        .data_o  (fifo_data),
        .pop_i   (fifo_pop)
    );

    always_comb begin
        drop_inc = '0;
        if (force_drain) drop_inc = (CNT_W + 1)'(fifo_usage);
        if (push_req && !fifo_push) drop_inc = drop_inc + 1'b1;
        drop_sum   = {1'b0, drop_cnt_q} + drop_inc;
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // Payload fields hold their last value while nothing is issued.
    always_comb begin
        upd_d       = upd_q;
        upd_d.valid = 1'b0;
        if (fifo_pop) begin
            upd_d       = fifo_data;
            upd_d.valid = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (ckpt_if.ckpt_req) begin
                    if (ckpt_if.ckpt_target == mode_q) begin
                        state_d = DONE;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (quiet || force_drain) state_d = SWITCH;
            end
            SWITCH: begin
                mode_d  = ckpt_if.ckpt_target;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            drain_cnt_q <= '0;
            drop_cnt_q  <= '0;
            upd_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            drain_cnt_q <= drain_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            upd_q       <= upd_d;
        end
    end

    assign ckpt_if.ckpt_ack        = (state_q == DONE);
    assign ckpt_if.checkpoint_mode = mode_q;
    assign bht_update_o            = upd_q;
    assign fifo_full_o             = fifo_full;
    assign drop_cnt_o              = drop_cnt_q;

endmodule
